// File: rtl/debounce_switch_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, tick-gated stability
// filter, press/release pulses and a one-shot long-press pulse.
module debounce_lane #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 8,
  parameter int   LONG_TICKS   = 200,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);
  localparam int SW = $clog2(STABLE_TICKS) + 1;
  localparam int LW = $clog2(LONG_TICKS) + 1;
  localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          lcnt_q, lcnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d, fall_q, fall_d, long_q, long_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
  end

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // Any return to the accepted level restarts the count, even without a tick.
    if (sync_s == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = sync_s;
        cnt_d  = '0;
        rise_d = sync_s;
        fall_d = ~sync_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    // Saturating at LONG_MAX makes the long pulse one-shot per press.
    if (!lvl_q) begin
      lcnt_d = '0;
    end else if (tick_i && lcnt_q != LONG_MAX) begin
      lcnt_d = lcnt_q + 1'b1;
      long_d = (lcnt_q == LONG_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lcnt_q <= '0;
      lvl_q  <= INIT_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lcnt_q <= lcnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      long_q <= long_d;
    end
  end

  assign sw_o   = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign long_o = long_q;
endmodule

module debounce_switch_multi #(
  parameter int   CHANNELS     = 4,
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 8,
  parameter int   LONG_TICKS   = 200,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_tick,
  input  logic [CHANNELS-1:0] i_switch,
  output logic [CHANNELS-1:0] o_switch,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_long
);
  debounce_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS  (LONG_TICKS),
    .INIT_LEVEL  (INIT_LEVEL)
  ) u_lane [CHANNELS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .tick_i(i_tick),
    .sw_i  (i_switch),
    .sw_o  (o_switch),
    .rise_o(o_rise),
    .fall_o(o_fall),
    .long_o(o_long)
  );
endmodule

// File: doc/debounce_switch_multi.md
Name: debounce_switch_multi

Overview:
- Parametrised multi-channel successor to the single-input switch debouncer.
- Synchronises N raw switch/button inputs and debounces each one against a shared tick enable. Intended tick source: the clock_enable_param strobe.
- Per channel, outputs a clean level, one-cycle press/release pulses and a one-shot long-press pulse.
- Sits between board pins and the control logic (reset, effect select, mode buttons).

Parameters:
- CHANNELS, 4, number of independent switch inputs (>=1).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- STABLE_TICKS, 8, consecutive ticks with a changed level needed to accept it (>=1).
- LONG_TICKS, 200, ticks a debounced level must stay 1 before o_long fires (>=1).
- INIT_LEVEL, 0, reset value of synchronisers and o_switch (0 or 1, all channels).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- i_tick, input, 1, sample enable; counters advance only when 1.
- i_switch, input, CHANNELS, raw asynchronous switch levels.
- o_switch, output, CHANNELS, debounced level.
- o_rise, output, CHANNELS, one-cycle pulse on accepted 0->1.
- o_fall, output, CHANNELS, one-cycle pulse on accepted 1->0.
- o_long, output, CHANNELS, one-cycle pulse when a held 1 reaches LONG_TICKS.

Behaviour:
- Clock, reset and outputs:
  - Single clock domain: clk. Reset: rst, asynchronous, active-high.
  - All outputs are registered.
  - On reset:
    - synchronisers and o_switch = INIT_LEVEL;
    - o_rise, o_fall, o_long = 0;
    - all counters = 0.
- Synchroniser: each i_switch bit passes through SYNC_STAGES flops. sync[c] is the last stage.
- Stable counter, per channel, width $clog2(STABLE_TICKS)+1:
  - If sync[c] == o_switch[c]: cnt <= 0, regardless of tick (any bounce restarts the count).
  - Else if i_tick and cnt == STABLE_TICKS-1:
    - o_switch[c] <= sync[c];
    - cnt <= 0;
    - o_rise[c] or o_fall[c] <= 1 for that single cycle.
  - Else if i_tick: cnt <= cnt+1.
  - Else: hold.
- Pulses: o_rise, o_fall and o_long are 0 in every cycle they are not explicitly set. o_rise and o_fall are never both 1 on one channel.
- Latency, i_tick held 1: count the edge that first samples the new level as edge 1. The new level reaches o_switch, with its pulse, at edge SYNC_STAGES+STABLE_TICKS. With sparse ticks, the update lands on the STABLE_TICKS-th tick after the level reaches sync[c].
- Long-press counter, per channel, width $clog2(LONG_TICKS)+1:
  - Cleared whenever o_switch[c] == 0, including the cycle o_rise fires.
  - While o_switch[c] == 1 and i_tick, it increments.
  - When it reaches LONG_TICKS, o_long[c] pulses once and the counter saturates: no repeat until a release and a new press.
  - Release before LONG_TICKS: no o_long.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- i_tick == 0 freezes counters but never blocks the cnt clear when the input returns to the debounced level.
- Reset mid-count discards all partial counts. After release, channels whose input differs from INIT_LEVEL re-debounce from zero.
- No combinational path from any input to any output.

Test Plan:
All cases use CHANNELS=2, SYNC_STAGES=2, STABLE_TICKS=4, LONG_TICKS=10, INIT_LEVEL=0, i_tick=1 unless stated.
1. Reset: assert rst with i_switch toggling -> o_switch=00 and all pulses 0 throughout; after release with i_switch=00, outputs stay 0.
2. Clean press: i_switch[0] 0->1 sampled at edge 1 -> o_switch[0]=1 and o_rise[0]=1 at edge 6, o_rise[0]=0 at edge 7; channel 1 unaffected.
3. Bounce: i_switch[0] toggles every 2 cycles for 20 cycles, then holds 1 -> no output change during the bounce; o_switch[0] rises 6 edges after the last transition. A release with the same bounce gives a single o_fall pulse.
4. Tick gating: i_tick high every 3rd cycle, clean press -> o_switch[0] updates on the 4th tick after sync[0] changes; no pulse between ticks.
5. Long press: hold i_switch[0]=1 -> o_rise at edge 6, exactly one o_long[0] pulse 10 ticks later (edge 16), none while still held; release -> o_fall. A second press held for only 5 ticks -> no o_long.
6. Simultaneous and reset: press both channels on the same edge -> o_rise=11 in one cycle. Pulse rst during a channel-0 count (cnt=2) -> outputs clear asynchronously; with the input still 1, o_switch[0] rises 6 edges after reset release.
